demo_iface_unit: RTL and testbench

//  - Registered bitwise-inverting data stage behind the demo interface signal set (data_in/data_valid/data_out).
//  - Captures ~data_in on each clock edge where data_valid=1 and holds it until the next valid beat.
//  - Provides a one-cycle output-valid strobe and a free-running count of accepted beats for bring-up/debug.

---
 rtl/demo_iface_pkg.sv | 15 +
 rtl/demo_iface_counter.sv | 33 +++
 rtl/demo_iface_unit.sv | 59 +++++
 tb/tb_demo_iface_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demo_iface_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demo_iface_pkg
// Brief    : Shared defaults and types for the demo interface data stage.
// Revision : 1.0 - initial release
// ============================================================================
package demo_iface_pkg;

    localparam int DATA_WIDTH_DEFAULT  = 8;
    localparam int COUNT_WIDTH_DEFAULT = 16;

    typedef logic [DATA_WIDTH_DEFAULT-1:0] data_t;

endpackage : demo_iface_pkg
`default_nettype wire

// File: rtl/demo_iface_counter.sv
`default_nettype none
// ============================================================================
// Module   : demo_iface_counter
// Brief    : Enable-driven wrapping counter with synchronous active-high reset.
//            Rolls over from all-ones to zero silently.
// Revision : 1.0 - initial release
// ============================================================================
module demo_iface_counter
    import demo_iface_pkg::*;
#(
    parameter int WIDTH = COUNT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count enabled cycles; reset wins over enable so a beat during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule : demo_iface_counter
`default_nettype wire

// File: rtl/demo_iface_unit.sv
`default_nettype none
// ============================================================================
// Module   : demo_iface_unit
// Brief    : Registered bitwise-inverting data stage. Captures ~data_in on each
//            valid beat, holds it, strobes data_out_valid for one cycle and
//            counts accepted beats. All outputs come straight from flops.
// Revision : 1.0 - initial release
// ============================================================================
module demo_iface_unit
    import demo_iface_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   data_valid,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   data_out_valid,
    output logic [COUNT_WIDTH-1:0] beat_count
);

    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_out_valid;

    // Hold register: load the inverted word only on a valid beat so that
    // data_in is never looked at (and X cannot leak) while data_valid is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_out <= '0;
        end else if (data_valid) begin
            r_data_out <= ~data_in;
        end
    end

    // Output strobe: high for exactly the cycle following each accepted beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_out_valid <= 1'b0;
        end else begin
            r_data_out_valid <= data_valid;
        end
    end

    demo_iface_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_beat_counter (
        .clk     (clock),
        .rst     (reset),
        .i_en    (data_valid),
        .o_count (beat_count)
    );

    assign data_out       = r_data_out;
    assign data_out_valid = r_data_out_valid;

endmodule : demo_iface_unit
`default_nettype wire

// File: tb/tb_demo_iface_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_demo_iface_unit
// Brief    : Self-checking bench for demo_iface_unit. A queue holds the words
//            expected on data_out; a second instance with a 4-bit counter
//            exercises counter wrap-around on the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demo_iface_unit;

    logic        clock;
    logic        reset;
    logic [7:0]  data_in;
    logic        data_valid;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic [15:0] beat_count;
    logic [7:0]  data_out_w4;
    logic        data_out_valid_w4;
    logic [3:0]  beat_count_w4;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  m_out;
    logic        m_vld;
    int          m_cnt;
    logic [7:0]  e;

    demo_iface_unit dut (
        .clock          (clock),
        .reset          (reset),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .beat_count     (beat_count)
    );

    demo_iface_unit #(
        .DATA_WIDTH  (8),
        .COUNT_WIDTH (4)
    ) dut_w4 (
        .clock          (clock),
        .reset          (reset),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .data_out       (data_out_w4),
        .data_out_valid (data_out_valid_w4),
        .beat_count     (beat_count_w4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of stimulus, update the reference model, sample #1 after the edge.
    task automatic cycle(input logic rst_v, input logic vld, input logic [7:0] din);
        @(negedge clock);
        reset      = rst_v;
        data_valid = vld;
        data_in    = din;
        if (rst_v) begin
            exp_q.delete();
            m_out = 8'h00;
            m_vld = 1'b0;
            m_cnt = 0;
        end else if (vld) begin
            exp_q.push_back(~din);
            m_out = ~din;
            m_vld = 1'b1;
            m_cnt = m_cnt + 1;
        end else begin
            m_vld = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 8'h00);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 8'bxxxx_xxxx);
            n_checks++;
            if (data_out !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_data_out cyc%0d: got %h expected 00", i, data_out);
            end
            n_checks++;
            if (data_out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_valid cyc%0d: got %b expected 0", i, data_out_valid);
            end
            n_checks++;
            if (beat_count !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_count cyc%0d: got %0d expected 0", i, beat_count);
            end
        end
    endtask

    task automatic test_single();
        cycle(1'b0, 1'b1, 8'h12);
        n_checks++;
        if (data_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_valid: got %b expected 1", data_out_valid);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL single_queue: got empty expected 1 entry");
        end else begin
            e = exp_q.pop_front();
            if (data_out !== e || data_out !== 8'hED) begin
                n_fail++;
                $display("FAIL single_data: got %h expected %h", data_out, e);
            end
        end
        n_checks++;
        if (beat_count !== 16'd1) begin
            n_fail++;
            $display("FAIL single_count: got %0d expected 1", beat_count);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 8'bxxxx_xxxx);
            n_checks++;
            if (data_out !== 8'hED || data_out_valid !== 1'b0 || beat_count !== 16'd1) begin
                n_fail++;
                $display("FAIL single_hold cyc%0d: got %h/%b/%0d expected ed/0/1",
                         i, data_out, data_out_valid, beat_count);
            end
        end
    endtask

    task automatic test_hold();
        cycle(1'b0, 1'b1, 8'h55);
        n_checks++;
        if (exp_q.size() == 0 || data_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_strobe: got valid %b expected 1", data_out_valid);
        end else begin
            e = exp_q.pop_front();
            if (data_out !== e) begin
                n_fail++;
                $display("FAIL hold_strobe: got %h expected %h", data_out, e);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 8'h00);
            n_checks++;
            if (data_out !== 8'hAA || data_out_valid !== m_vld || beat_count !== 16'(m_cnt)) begin
                n_fail++;
                $display("FAIL hold_data cyc%0d: got %h/%b/%0d expected aa/%b/%0d",
                         i, data_out, data_out_valid, beat_count, m_vld, m_cnt);
            end
        end
        n_checks++;
        if (beat_count !== 16'd2) begin
            n_fail++;
            $display("FAIL hold_count: got %0d expected 2", beat_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] stim [3];
        logic [7:0] want [3];
        stim[0] = 8'h00; stim[1] = 8'hFF; stim[2] = 8'h0F;
        want[0] = 8'hFF; want[1] = 8'h00; want[2] = 8'hF0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, stim[i]);
            n_checks++;
            if (data_out_valid !== 1'b1 || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_valid beat%0d: got %b expected 1", i, data_out_valid);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e || data_out !== want[i]) begin
                    n_fail++;
                    $display("FAIL b2b_data beat%0d: got %h expected %h", i, data_out, want[i]);
                end
            end
        end
        n_checks++;
        if (beat_count !== 16'd5) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected 5", beat_count);
        end
        cycle(1'b0, 1'b0, 8'h77);
        n_checks++;
        if (data_out_valid !== 1'b0 || data_out !== 8'hF0) begin
            n_fail++;
            $display("FAIL b2b_tail: got %h/%b expected f0/0", data_out, data_out_valid);
        end
    endtask

    task automatic test_reset_beat();
        cycle(1'b1, 1'b1, 8'h33);
        n_checks++;
        if (data_out !== 8'h00 || data_out_valid !== 1'b0 || beat_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_beat: got %h/%b/%0d expected 00/0/0",
                     data_out, data_out_valid, beat_count);
        end
        cycle(1'b0, 1'b1, 8'hC3);
        n_checks++;
        if (exp_q.size() == 0 || data_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_first_beat: got valid %b expected 1", data_out_valid);
        end else begin
            e = exp_q.pop_front();
            if (data_out !== e || beat_count !== 16'd1) begin
                n_fail++;
                $display("FAIL rst_first_beat: got %h/%0d expected %h/1", data_out, beat_count, e);
            end
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 17; i++) begin
            cycle(1'b0, 1'b1, 8'($urandom));
            n_checks++;
            if (exp_q.size() == 0 || data_out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_valid beat%0d: got %b expected 1", i, data_out_valid);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e || data_out_w4 !== m_out) begin
                    n_fail++;
                    $display("FAIL wrap_data beat%0d: got %h/%h expected %h",
                             i, data_out, data_out_w4, e);
                end
            end
            if (i == 15 || i == 16) begin
                n_checks++;
                if (beat_count_w4 !== 4'(m_cnt)) begin
                    n_fail++;
                    $display("FAIL wrap_edge beat%0d: got %0d expected %0d",
                             i, beat_count_w4, 4'(m_cnt));
                end
            end
        end
        n_checks++;
        if (beat_count_w4 !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap_count4: got %0d expected 1", beat_count_w4);
        end
        n_checks++;
        if (beat_count !== 16'd17) begin
            n_fail++;
            $display("FAIL wrap_count16: got %0d expected 17", beat_count);
        end
        n_checks++;
        if (data_out_valid_w4 !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_valid4: got %b expected 1", data_out_valid_w4);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        data_valid = 1'b0;
        data_in    = 8'h00;
        m_out      = 8'h00;
        m_vld      = 1'b0;
        m_cnt      = 0;
        test_reset();
        test_single();
        test_hold();
        test_back_to_back();
        test_reset_beat();
        test_wrap();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_demo_iface_unit
`default_nettype wire
